// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : seven_segment_scanner
//  Purpose  : Time-multiplexed driver for a common-anode seven-segment display.
//             A prescaler divides each digit slot into DWELL_CYCLES clocks.
//             The first clock of every slot is blanked to suppress ghosting.
//             The BCD input is captured once per full scan, so a value that
//             changes mid-scan never shows as a torn mix of old and new digits.
//  Options  : `define LEADING_ZERO_BLANK_EN blanks leading zero digits.
//             Digit 0 is never blanked. Ports and timing are unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
    parameter int NUMBER_OF_DIGITS         = 4,
    parameter int NUMBER_OF_BITS_PER_DIGIT = 4,
    parameter int DWELL_CYCLES             = 100_000,
    parameter int DP_DIGIT                 = 2
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
    output logic [6:0]                                           segments,
    output logic [NUMBER_OF_DIGITS-1:0]                          anodes,
    output logic                                                 dp
);

    localparam int NUM_W = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
    localparam int P_W   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int IDX_W = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;

    localparam logic [P_W-1:0]   P_LAST   = P_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUMBER_OF_DIGITS - 1);

    // A decimal-point index outside the digit range simply never lights.
    localparam bit               DP_VALID = (DP_DIGIT >= 0) && (DP_DIGIT < NUMBER_OF_DIGITS);
    localparam logic [IDX_W-1:0] DP_IDX   = IDX_W'(DP_VALID ? DP_DIGIT : 0);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [NUMBER_OF_DIGITS-1:0] ANODES_OFF = '1;
    localparam logic [NUMBER_OF_DIGITS-1:0] ANODE_BASE = NUMBER_OF_DIGITS'(1);

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [P_W-1:0]   p;
    logic [IDX_W-1:0] idx;
    logic [NUM_W-1:0] shadow;

    logic slot_end;
    logic scan_end;

    assign slot_end = (p == P_LAST);
    assign scan_end = slot_end && (idx == IDX_LAST);

    // Prescaler: counts 0..DWELL_CYCLES-1 within each digit slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
        end else if (slot_end) begin
            p <= '0;
        end else begin
            p <= p + P_W'(1);
        end
    end

    // Digit index: steps to the next digit at the end of each slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (slot_end) begin
            if (idx == IDX_LAST) begin
                idx <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Shadow copy of the number: loaded only on the last clock of a scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (scan_end) begin
            shadow <= number;
        end
    end

    // ------------------------------------------------------------------
    // Digit selection and decode
    // ------------------------------------------------------------------
    logic [NUMBER_OF_BITS_PER_DIGIT-1:0] digit_val [NUMBER_OF_DIGITS];

    for (genvar k = 0; k < NUMBER_OF_DIGITS; k++) begin : g_digit_split
        assign digit_val[k] = shadow[k*NUMBER_OF_BITS_PER_DIGIT +: NUMBER_OF_BITS_PER_DIGIT];
    end

    logic [NUMBER_OF_BITS_PER_DIGIT-1:0] cur_digit;
    assign cur_digit = digit_val[idx];

    // A leading-zero digit is blanked only when it and every higher digit are 0.
    logic blank_digit;
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUMBER_OF_DIGITS-1:0] upper_zero;

    for (genvar k = 0; k < NUMBER_OF_DIGITS; k++) begin : g_upper_zero
        assign upper_zero[k] = (shadow[NUM_W-1:k*NUMBER_OF_BITS_PER_DIGIT] == '0);
    end

    assign blank_digit = (idx != '0) && upper_zero[idx];
`else
    assign blank_digit = 1'b0;
`endif

    // Active-low {g,f,e,d,c,b,a}. Values above 9 show a dash.
    function automatic logic [6:0] decode_digit(input logic [NUMBER_OF_BITS_PER_DIGIT-1:0] v);
        logic [6:0]  s;
        int unsigned val;
        val = 32'(v);
        case (val)
            0:       s = 7'h40;
            1:       s = 7'h79;
            2:       s = 7'h24;
            3:       s = 7'h30;
            4:       s = 7'h19;
            5:       s = 7'h12;
            6:       s = 7'h02;
            7:       s = 7'h78;
            8:       s = 7'h00;
            9:       s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    logic [6:0] digit_segments;
    assign digit_segments = blank_digit ? SEG_BLANK : decode_digit(cur_digit);

    // Output registers: pins reflect the previous cycle's p, idx and shadow.
    // The first clock of every slot is dark to avoid ghosting between digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            anodes   <= ANODES_OFF;
            segments <= SEG_BLANK;
            dp       <= 1'b1;
        end else if (p == '0) begin
            anodes   <= ANODES_OFF;
            segments <= SEG_BLANK;
            dp       <= 1'b1;
        end else begin
            anodes   <= ~(ANODE_BASE << idx);
            segments <= digit_segments;
            dp       <= ~(DP_VALID && (idx == DP_IDX));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_segment_scanner
//  Purpose  : Self-checking bench for seven_segment_scanner. The expected pins
//             come from a cycle-count model. Slot, digit and scan number are
//             derived arithmetically from the steps since reset release.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scanner;

    localparam int ND  = 4;
    localparam int BW  = 4;
    localparam int DW  = 4;
    localparam int DPD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] number = 16'h0000;
    logic [6:0]  segments;
    logic [3:0]  anodes;
    logic        dp;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    int          cyc = 0;
    logic [15:0] mshadow = 16'h0000;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [6:0]  seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seven_segment_scanner #(
        .NUMBER_OF_DIGITS        (ND),
        .NUMBER_OF_BITS_PER_DIGIT(BW),
        .DWELL_CYCLES            (DW),
        .DP_DIGIT                (DPD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .number  (number),
        .segments(segments),
        .anodes  (anodes),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    // Pattern for a zero shadow digit k.
    function automatic logic [6:0] zero_seg(input int k);
`ifdef LEADING_ZERO_BLANK_EN
        return (k > 0) ? 7'h7F : 7'h40;
`else
        return 7'h40;
`endif
    endfunction

    // Advance one clock and update the model. Outputs are sampled 1 time unit after the edge.
    task automatic clock_cycle();
        int pp;
        int ii;
        int dig;
        @(posedge clk);
        if (rst) begin
            exp_an  = 4'b1111;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            cyc     = 0;
            mshadow = 16'h0000;
        end else begin
            pp = cyc % DW;
            ii = (cyc / DW) % ND;
            if (pp == 0) begin
                exp_an  = 4'b1111;
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end else begin
                exp_an     = 4'b1111;
                exp_an[ii] = 1'b0;
                dig        = int'((mshadow >> (4 * ii)) & 16'h000F);
                exp_seg    = (dig <= 9) ? seg_tab[dig] : 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
                if (ii > 0 && (mshadow >> (4 * ii)) == 16'h0000) exp_seg = 7'h7F;
`endif
                exp_dp = (ii == DPD) ? 1'b0 : 1'b1;
            end
            if (pp == DW - 1 && ii == ND - 1) mshadow = number;
            cyc++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        number = 16'h9876;
        for (int j = 0; j < 3; j++) begin
            clock_cycle();
            if ({anodes, segments, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
                fails++;
                $display("FAIL reset[%0d] got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1",
                         j, anodes, segments, dp);
            end
            checks++;
        end
    endtask

    // First scan after release: the anode walk, dp position and "0000" display.
    task automatic test_scan_timing();
        logic [3:0] an_seq [16] = '{4'b1111, 4'b1110, 4'b1110, 4'b1110,
                                    4'b1111, 4'b1101, 4'b1101, 4'b1101,
                                    4'b1111, 4'b1011, 4'b1011, 4'b1011,
                                    4'b1111, 4'b0111, 4'b0111, 4'b0111};
        logic [6:0] want_seg;
        rst    = 1'b0;
        number = 16'h1234;
        for (int j = 0; j < 16; j++) begin
            clock_cycle();
            want_seg = (j % 4 == 0) ? 7'h7F : zero_seg(j / 4);
            if (anodes !== an_seq[j] || dp !== (an_seq[j] == 4'b1011 ? 1'b0 : 1'b1)
                || segments !== want_seg) begin
                fails++;
                $display("FAIL scan_timing[%0d] got an=%b seg=%h dp=%b want an=%b seg=%h",
                         j, anodes, segments, dp, an_seq[j], want_seg);
            end
            checks++;
        end
    endtask

    // Second scan shows the value captured at the end of the first scan.
    task automatic test_first_capture();
        logic [6:0] t1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        logic [6:0] want_seg;
        for (int j = 16; j < 32; j++) begin
            clock_cycle();
            want_seg = (j % 4 == 0) ? 7'h7F : t1234[(j / 4) % 4];
            if (segments !== want_seg || {anodes, segments, dp} !== {exp_an, exp_seg, exp_dp}) begin
                fails++;
                $display("FAIL first_capture[%0d] got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         j, anodes, segments, dp, exp_an, want_seg, exp_dp);
            end
            checks++;
        end
    endtask

    // A change in number during a scan must wait for the next scan boundary.
    task automatic test_tearing();
        logic [6:0] t1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        logic [6:0] t5959 [4] = '{7'h10, 7'h12, 7'h10, 7'h12};
        logic [6:0] want_seg;
        rst = 1'b1;
        clock_cycle();
        rst    = 1'b0;
        number = 16'h1234;
        for (int j = 0; j < 48; j++) begin
            if (j == 21) number = 16'h5959;
            clock_cycle();
            if (j < 16)           want_seg = (j % 4 == 0) ? 7'h7F : zero_seg(j / 4);
            else if (j < 32)      want_seg = (j % 4 == 0) ? 7'h7F : t1234[(j / 4) % 4];
            else                  want_seg = (j % 4 == 0) ? 7'h7F : t5959[(j / 4) % 4];
            if (segments !== want_seg || {anodes, segments, dp} !== {exp_an, exp_seg, exp_dp}) begin
                fails++;
                $display("FAIL tearing[%0d] got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         j, anodes, segments, dp, exp_an, want_seg, exp_dp);
            end
            checks++;
        end
    endtask

    // A non-BCD digit shows a dash. Leading zeros follow the build option.
    task automatic test_dash();
        logic [6:0] t00a7 [4];
        logic [6:0] want_seg;
        t00a7[0] = 7'h78;
        t00a7[1] = 7'h3F;
        t00a7[2] = zero_seg(2);
        t00a7[3] = zero_seg(3);
        rst = 1'b1;
        clock_cycle();
        rst    = 1'b0;
        number = 16'h00A7;
        for (int j = 0; j < 32; j++) begin
            clock_cycle();
            want_seg = (j % 4 == 0) ? 7'h7F : ((j < 16) ? zero_seg(j / 4) : t00a7[(j / 4) % 4]);
            if (segments !== want_seg || {anodes, segments, dp} !== {exp_an, exp_seg, exp_dp}) begin
                fails++;
                $display("FAIL dash[%0d] got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         j, anodes, segments, dp, exp_an, want_seg, exp_dp);
            end
            checks++;
        end
    endtask

    // Reset at idx=2, p=2 blanks at once and restarts the scan from digit 0 showing 0.
    task automatic test_reset_midscan();
        int guard = 0;
        number = 16'h4321;
        while (cyc % (DW * ND) != 10 && guard < 40) begin
            clock_cycle();
            guard++;
        end
        if (cyc % (DW * ND) != 10) begin
            fails++;
            $display("FAIL reset_midscan_position got step=%0d want step=10", cyc % (DW * ND));
        end
        checks++;
        rst = 1'b1;
        clock_cycle();
        if ({anodes, segments, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
            fails++;
            $display("FAIL reset_midscan_blank got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1",
                     anodes, segments, dp);
        end
        checks++;
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            clock_cycle();
            if (anodes !== ((j % 4 == 0) ? 4'b1111 : 4'b1110)
                || segments !== ((j % 4 == 0) ? 7'h7F : 7'h40) || dp !== 1'b1) begin
                fails++;
                $display("FAIL reset_midscan_restart[%0d] got an=%b seg=%h dp=%b", j, anodes, segments, dp);
            end
            checks++;
        end
    endtask

    // Random values, including non-BCD digits, changing at random times, with occasional resets.
    task automatic test_random();
        rst = 1'b0;
        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 7) == 0) number = 16'($urandom);
            if ($urandom_range(0, 3) == 0) number[3:0] = 4'h0;
            if ($urandom_range(0, 1) == 0) number[15:8] = 8'h00;
            rst = ($urandom_range(0, 63) == 0);
            clock_cycle();
            if ({anodes, segments, dp} !== {exp_an, exp_seg, exp_dp}) begin
                fails++;
                $display("FAIL random[%0d] got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                         j, anodes, segments, dp, exp_an, exp_seg, exp_dp);
            end
            checks++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_first_capture();
        test_tearing();
        test_dash();
        test_reset_midscan();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 Parameter NUMBER_OF_DIGITS, default 4: digits scanned.
REQ-002 Parameter NUMBER_OF_BITS_PER_DIGIT, default 4: BCD width per digit.
REQ-003 Parameter DWELL_CYCLES, default 100_000: clk cycles per digit slot; legal range >= 2.
REQ-004 Parameter DP_DIGIT, default 2: digit index whose decimal point is lit.
REQ-005 clk  input  1: single clock; all state updates on rising edge.
REQ-006 rst  input  1: synchronous, active-high reset.
REQ-007 number  input  NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT: packed BCD from the stopwatch counter; digit k at bits [4k+3:4k], digit 0 = seconds units.
REQ-008 segments  output  7: active-low segment drive, bit order {g,f,e,d,c,b,a}, registered.
REQ-009 anodes  output  NUMBER_OF_DIGITS: active-low digit select, one-hot-low or all-high, registered.
REQ-010 dp  output  1: active-low decimal point, registered.

Function
REQ-011 Internal prescaler p SHALL count 0..DWELL_CYCLES-1 and wrap to 0.
REQ-012 Digit index idx SHALL advance by 1 on each cycle where p==DWELL_CYCLES-1, wrapping from NUMBER_OF_DIGITS-1 to 0.
REQ-013 Shadow register SHALL capture number only on the cycle where p==DWELL_CYCLES-1 and idx==NUMBER_OF_DIGITS-1; number changes at other times SHALL NOT affect the display until the next capture (no mid-scan tearing).
REQ-014 Outputs SHALL be registered from the current p, idx and shadow: one-cycle latency from state to pins.
REQ-015 Blanking: when p==0, next-edge outputs SHALL be anodes all 1, segments 7'h7F, dp 1 (anti-ghosting gap of one cycle per slot).
REQ-016 When p!=0, next-edge anodes SHALL be all 1 except bit idx = 0.
REQ-017 Decode (active-low {g..a}): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10 (hex).
REQ-018 Shadow digit value 10..15 SHALL decode to 3F (only g lit, dash).
REQ-019 dp SHALL be 0 when p!=0 and idx==DP_DIGIT, otherwise 1.
REQ-020 A number change that coincides with the capture cycle SHALL be captured as its value in that cycle.
REQ-021 Full scan period SHALL be exactly NUMBER_OF_DIGITS*DWELL_CYCLES cycles, with no dropped or repeated slots.

Reset
REQ-022 While rst is high at a clock edge: p=0, idx=0, shadow=0, anodes all 1, segments 7'h7F, dp 1.
REQ-023 Reset asserted mid-scan SHALL override all other updates on that edge; no partial capture.
REQ-024 After reset release the first scan SHALL display shadow=0 (digits "0000"); the first capture occurs at the end of that scan.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN: when defined, digit k>0 SHALL drive segments 7'h7F (anode still selected) if shadow digits k..NUMBER_OF_DIGITS-1 are all 0; digit 0 is never blanked.
REQ-026 When LEADING_ZERO_BLANK_EN is undefined, all digits SHALL be decoded per REQ-017/018; ports and timing identical in both builds.

Verification (DWELL_CYCLES=4, NUMBER_OF_DIGITS=4)
REQ-027 Reset, then number=16'h1234 held -> first 16 cycles show 0 on each digit; second scan shows digit0=4(19), digit1=3(30), digit2=2(24), digit3=1(79), each anode low for 3 of 4 cycles.
REQ-028 Scan timing -> anodes sequence 1111,1110,1110,1110,1111,1101,... repeating every 16 cycles; dp low exactly while anodes==1011.
REQ-029 Change number 16'h1234->16'h5959 mid-scan at digit 1 -> remainder of the scan still shows 1234; next scan shows 5959.
REQ-030 number=16'h00A7 -> digit1 shows 3F (dash), digit0 shows 78; with LEADING_ZERO_BLANK_EN digits 3,2 show 7F, without it they show 40.
REQ-031 Assert rst for 1 cycle at idx=2, p=2 -> next cycle anodes=1111, segments=7F, dp=1; scan restarts at digit 0 showing 0.
